// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin 8:1 mux arbiter.
//   N_REQ       number of requesters
//   SEL_W       width of a requester index / mux select
//   arb_state_t IDLE (no owner) / OWN (locked owner holds the grant)
//   rr_next     mod-8 increment of a requester index
package arb_pkg;

    localparam int N_REQ = 8;
    localparam int SEL_W = 3;

    typedef enum logic {
        IDLE,
        OWN
    } arb_state_t;

    function automatic logic [SEL_W-1:0] rr_next(input logic [SEL_W-1:0] p);
        return p + SEL_W'(1);
    endfunction

endpackage

// File: rtl/rr_mux8_arbiter_if.sv
// Requester/consumer bundle for rr_mux8_arbiter.
//   req_valid  [8]        requester i has a word on slice i of req_data
//   req_lock   [8]        requester i asks to keep the grant after this beat
//   req_data   [8*WIDTH]  slice i = req_data[i*WIDTH +: WIDTH]
//   req_ready  [8]        one-hot/zero, word i captured this cycle
//   out_valid             out_data/out_src hold a valid beat
//   out_ready             consumer accepts the beat
//   out_data   [WIDTH]    captured word
//   out_src    [3]        index of the requester that supplied out_data
// master: producers + consumer side; slave: the arbiter.
interface rr_mux8_arbiter_if
    import arb_pkg::*;
#(
    parameter int WIDTH = 32
) ();

    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ-1:0]       req_lock;
    logic [N_REQ*WIDTH-1:0] req_data;
    logic [N_REQ-1:0]       req_ready;
    logic                   out_valid;
    logic                   out_ready;
    logic [WIDTH-1:0]       out_data;
    logic [SEL_W-1:0]       out_src;

    modport master (
        output req_valid, req_lock, req_data, out_ready,
        input  req_ready, out_valid, out_data, out_src
    );

    modport slave (
        input  req_valid, req_lock, req_data, out_ready,
        output req_ready, out_valid, out_data, out_src
    );

endinterface

// File: rtl/rr_prio_pick8.sv
// Rotating-priority encoder: returns the first set bit of req scanning
// ptr, ptr+1, ... ptr+7 (mod 8).
//   req  [8]  request vector
//   ptr  [3]  highest-priority index
//   any       at least one request set
//   idx  [3]  winning index (0 when any=0)
module rr_prio_pick8
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic             any,
    output logic [SEL_W-1:0] idx
);

    always_comb begin : pick
        logic [SEL_W-1:0] cand;
        cand = '0;
        any  = 1'b0;
        idx  = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            cand = ptr + SEL_W'(k);
            if (!any && req[cand]) begin
                any = 1'b1;
                idx = cand;
            end
        end
    end

endmodule

// File: rtl/rr_mux8_arbiter.sv
// Round-robin arbiter sharing one 8:1 WIDTH-bit mux among 8 requesters,
// with a registered valid/ready output and locked bursts of up to
// MAX_BURST beats.
//   clk   clock, rising edge
//   rst   asynchronous reset, active-high
//   bus   rr_mux8_arbiter_if slave side (requests in, captured beat out)
//   busy  high while a locked owner holds the grant
module rr_mux8_arbiter
    import arb_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int MAX_BURST = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    rr_mux8_arbiter_if.slave      bus,
    output logic                  busy
);

    localparam int CW = $clog2(MAX_BURST + 1);

    arb_state_t       state, state_d;
    logic [SEL_W-1:0] ptr, ptr_d;
    logic [SEL_W-1:0] owner, owner_d;
    logic [CW-1:0]    beat_cnt, beat_d;
    logic [SEL_W-1:0] g, pick_idx;
    logic             pick_any, cap, own_hold, fire;
    logic [WIDTH-1:0] words [N_REQ];

    for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
        assign words[i] = bus.req_data[i*WIDTH +: WIDTH];
    end

    rr_prio_pick8 u_pick (
        .req (bus.req_valid),
        .ptr (ptr),
        .any (pick_any),
        .idx (pick_idx)
    );

    // A valid locked owner beats the RR scan; otherwise the scan picks.
    always_comb begin
        cap      = ~bus.out_valid | bus.out_ready;
        own_hold = (state == OWN) && bus.req_valid[owner];
        g        = own_hold ? owner : pick_idx;
        fire     = cap && (own_hold || pick_any) && !rst;
        bus.req_ready = '0;
        if (fire) begin
            bus.req_ready[g] = 1'b1;
        end
    end

    always_comb begin
        state_d = state;
        ptr_d   = ptr;
        owner_d = owner;
        beat_d  = beat_cnt;
        if (fire) begin
            if (bus.req_lock[g] && (int'(beat_cnt) + 1 < MAX_BURST)) begin
                state_d = OWN;
                owner_d = g;
                beat_d  = beat_cnt + CW'(1);
            end else begin
                state_d = IDLE;
                ptr_d   = rr_next(g);
                beat_d  = '0;
            end
        end else if (cap && state == OWN) begin
            // Owner dropped and nobody else is requesting.
            state_d = IDLE;
            ptr_d   = rr_next(owner);
            beat_d  = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= '0;
            owner    <= '0;
            beat_cnt <= '0;
        end else begin
            state    <= state_d;
            ptr      <= ptr_d;
            owner    <= owner_d;
            beat_cnt <= beat_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_src   <= '0;
        end else if (fire) begin
            bus.out_valid <= 1'b1;
            bus.out_data  <= words[g];
            bus.out_src   <= g;
        end else if (cap) begin
            bus.out_valid <= 1'b0;
        end
    end

    assign busy = (state == OWN);

endmodule

// File: tb/tb_rr_mux8_arbiter.sv
module tb_rr_mux8_arbiter;

    localparam int WIDTH     = 32;
    localparam int MAX_BURST = 4;

    typedef struct {
        logic [7:0] valid;
        logic [7:0] lock;
        logic       ordy;
        logic [7:0] exp_rr;
        logic       exp_ov;
        logic [2:0] exp_src;
        logic       exp_busy;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy;
    int   checks = 0;
    int   errors = 0;
    vec_t tbl [22];

    rr_mux8_arbiter_if #(.WIDTH(WIDTH)) bus ();

    rr_mux8_arbiter #(
        .WIDTH     (WIDTH),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] pat(input int i);
        return 32'(i + 1) * 32'h1111_1111;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    // Inputs are applied just after an edge; req_ready is checked
    // combinationally, registered outputs just after the next edge.
    task automatic run(input vec_t v, input string tag);
        bus.req_valid = v.valid;
        bus.req_lock  = v.lock;
        bus.out_ready = v.ordy;
        #1;
        chk({tag, ".req_ready"}, 32'(bus.req_ready), 32'(v.exp_rr));
        @(posedge clk);
        #1;
        chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'(v.exp_ov));
        chk({tag, ".busy"}, 32'(busy), 32'(v.exp_busy));
        if (v.exp_ov) begin
            chk({tag, ".out_src"}, 32'(bus.out_src), 32'(v.exp_src));
            chk({tag, ".out_data"}, bus.out_data, pat(int'(v.exp_src)));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 8; i++) bus.req_data[i*WIDTH +: WIDTH] = pat(i);
        bus.req_valid = 8'hFF;
        bus.req_lock  = 8'h00;
        bus.out_ready = 1'b1;

        // all-request rotation 0..7,0
        for (int k = 0; k < 9; k++)
            tbl[k] = '{8'hFF, 8'h00, 1'b1, 8'(1 << (k % 8)), 1'b1, 3'(k % 8), 1'b0};
        // locked burst of req1 capped at 4 beats, req5 interleaved
        tbl[9]  = '{8'h22, 8'h02, 1'b1, 8'h02, 1'b1, 3'd1, 1'b1};
        tbl[10] = '{8'h22, 8'h02, 1'b1, 8'h02, 1'b1, 3'd1, 1'b1};
        tbl[11] = '{8'h22, 8'h02, 1'b1, 8'h02, 1'b1, 3'd1, 1'b1};
        tbl[12] = '{8'h22, 8'h02, 1'b1, 8'h02, 1'b1, 3'd1, 1'b0};
        tbl[13] = '{8'h22, 8'h02, 1'b1, 8'h20, 1'b1, 3'd5, 1'b0};
        tbl[14] = '{8'h22, 8'h02, 1'b1, 8'h02, 1'b1, 3'd1, 1'b1};
        // owner 1 drops with nobody else: back to IDLE, ptr=2
        tbl[15] = '{8'h00, 8'h00, 1'b1, 8'h00, 1'b0, 3'd0, 1'b0};
        // owner 3 locks, then drops while req6 valid: 6 wins same cycle, ptr=7
        tbl[16] = '{8'h08, 8'h08, 1'b1, 8'h08, 1'b1, 3'd3, 1'b1};
        tbl[17] = '{8'h40, 8'h00, 1'b1, 8'h40, 1'b1, 3'd6, 1'b0};
        // ptr=7 with req0/req7: 7 then 0
        tbl[18] = '{8'h81, 8'h00, 1'b1, 8'h80, 1'b1, 3'd7, 1'b0};
        tbl[19] = '{8'h81, 8'h00, 1'b1, 8'h01, 1'b1, 3'd0, 1'b0};
        tbl[20] = '{8'h00, 8'h00, 1'b1, 8'h00, 1'b0, 3'd0, 1'b0};
        tbl[21] = '{8'h00, 8'h00, 1'b1, 8'h00, 1'b0, 3'd0, 1'b0};

        // reset state with all requests pending
        #1;
        chk("rst.req_ready", 32'(bus.req_ready), 32'h0);
        chk("rst.out_valid", 32'(bus.out_valid), 32'h0);
        chk("rst.out_data", bus.out_data, 32'h0);
        chk("rst.out_src", 32'(bus.out_src), 32'h0);
        chk("rst.busy", 32'(busy), 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int k = 0; k < 22; k++) run(tbl[k], $sformatf("vec%0d", k));

        // backpressure: beat from req1 held for 5 cycles, then drain
        run('{8'hFF, 8'h00, 1'b1, 8'h02, 1'b1, 3'd1, 1'b0}, "bp.load");
        for (int k = 0; k < 5; k++)
            run('{8'hFF, 8'h00, 1'b0, 8'h00, 1'b1, 3'd1, 1'b0}, $sformatf("bp.hold%0d", k));
        run('{8'hFF, 8'h00, 1'b1, 8'h04, 1'b1, 3'd2, 1'b0}, "bp.release");
        run('{8'h00, 8'h00, 1'b0, 8'h00, 1'b1, 3'd2, 1'b0}, "bp.stall");
        run('{8'h00, 8'h00, 1'b1, 8'h00, 1'b0, 3'd2, 1'b0}, "bp.drain");

        // async reset mid-burst, between edges
        run('{8'h10, 8'h10, 1'b1, 8'h10, 1'b1, 3'd4, 1'b1}, "mid.lock4");
        #2;
        rst = 1'b1;
        #1;
        chk("mid.req_ready", 32'(bus.req_ready), 32'h0);
        chk("mid.out_valid", 32'(bus.out_valid), 32'h0);
        chk("mid.out_data", bus.out_data, 32'h0);
        chk("mid.out_src", 32'(bus.out_src), 32'h0);
        chk("mid.busy", 32'(busy), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        run('{8'hFF, 8'h00, 1'b1, 8'h01, 1'b1, 3'd0, 1'b0}, "post.g0");
        run('{8'hFF, 8'h00, 1'b1, 8'h02, 1'b1, 3'd1, 1'b0}, "post.g1");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
